sparse_operand_feeder: RTL and testbench

Upstream operand stage for the sparse-aware PE. It buffers streamed input/weight pairs in a small FIFO and drops pairs the PE would skip anyway, using the same magnitude-threshold rule. It drives the PE's `en`, `input_data`, `weight_data` and `mode_residual` for one dot product of programmable length. It then issues flush cycles so the PE's registered `output_data` reflects the final accumulation, and reports issued/skipped pair counts.

---
 rtl/sparse_operand_feeder.sv | 144 ++++++++++++++
 tb/tb_sparse_operand_feeder.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sparse_operand_feeder.sv
// Operand feeder for the sparse-aware PE: FIFO-buffers input/weight pairs, drops sparse ones,
// drives one dot product then two zero-operand flush issues so the PE's registered output settles.
module sparse_operand_feeder #(
    parameter int                    DATA_WIDTH         = 16,
    parameter logic [DATA_WIDTH-1:0] SPARSITY_THRESHOLD = 16'h0010,
    parameter int                    FIFO_DEPTH         = 8,
    parameter int                    LEN_WIDTH          = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  vec_len,
    input  logic                  residual_mode,
    input  logic                  hold,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_input,
    input  logic [DATA_WIDTH-1:0] in_weight,
    output logic                  pe_en,
    output logic [DATA_WIDTH-1:0] pe_input_data,
    output logic [DATA_WIDTH-1:0] pe_weight_data,
    output logic                  pe_mode_residual,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_WIDTH-1:0]  issued_count,
    output logic [LEN_WIDTH-1:0]  skipped_count
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] fifo_in [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_wt [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [AW:0]           count;
    logic [LEN_WIDTH-1:0]  len, accepted, popped;
    logic                  flush_idx;
    logic                  push, pop, last_pop, head_sparse;

    // Magnitude is formed one bit wider so the most-negative value is not mistaken for small.
    function automatic logic is_sparse(input logic [DATA_WIDTH-1:0] x);
        logic [DATA_WIDTH:0] ext;
        logic [DATA_WIDTH:0] mag;
        ext = {x[DATA_WIDTH-1], x};
        mag = x[DATA_WIDTH-1] ? -ext : ext;
        return (mag < {1'b0, SPARSITY_THRESHOLD}) || (x == '0);
    endfunction

    assign in_ready    = (state == RUN) && (count < (AW+1)'(FIFO_DEPTH)) && (accepted < len);
    assign push        = in_valid && in_ready;
    assign pop         = (state == RUN) && !hold && (count != '0);
    assign last_pop    = pop && (popped == len - LEN_WIDTH'(1));
    assign head_sparse = is_sparse(fifo_in[rd_ptr]) || is_sparse(fifo_wt[rd_ptr]);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (vec_len == '0) ? DONE : RUN;
            RUN:     if (last_pop) state_nxt = FLUSH;
            FLUSH:   if (!hold && flush_idx) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_in[wr_ptr] <= in_input;
            fifo_wt[wr_ptr] <= in_weight;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len              <= '0;
            accepted         <= '0;
            popped           <= '0;
            flush_idx        <= 1'b0;
            pe_en            <= 1'b0;
            pe_input_data    <= '0;
            pe_weight_data   <= '0;
            pe_mode_residual <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            issued_count     <= '0;
            skipped_count    <= '0;
        end else begin
            done  <= (state == DONE);
            busy  <= (state_nxt != IDLE);
            pe_en <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    len              <= vec_len;
                    pe_mode_residual <= residual_mode;
                    accepted         <= '0;
                    popped           <= '0;
                    flush_idx        <= 1'b0;
                    issued_count     <= '0;
                    skipped_count    <= '0;
                end
                RUN: begin
                    if (push) accepted <= accepted + LEN_WIDTH'(1);
                    if (pop) begin
                        popped <= popped + LEN_WIDTH'(1);
                        if (head_sparse) begin
                            skipped_count <= skipped_count + LEN_WIDTH'(1);
                        end else begin
                            pe_en          <= 1'b1;
                            pe_input_data  <= fifo_in[rd_ptr];
                            pe_weight_data <= fifo_wt[rd_ptr];
                            issued_count   <= issued_count + LEN_WIDTH'(1);
                        end
                    end
                end
                // Zero operands push the final accumulation through the PE's output register.
                FLUSH: if (!hold) begin
                    pe_en          <= 1'b1;
                    pe_input_data  <= '0;
                    pe_weight_data <= '0;
                    flush_idx      <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sparse_operand_feeder.sv
// Directed bench for sparse_operand_feeder with a behavioural PE accumulator and an issue-order scoreboard.
module tb_sparse_operand_feeder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] vec_len = '0;
    logic        residual_mode = 1'b0;
    logic        hold = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_input = '0;
    logic [15:0] in_weight = '0;
    logic        pe_en;
    logic [15:0] pe_input_data, pe_weight_data;
    logic        pe_mode_residual, busy, done;
    logic [15:0] issued_count, skipped_count;

    sparse_operand_feeder dut (
        .clk(clk), .rst(rst), .start(start), .vec_len(vec_len),
        .residual_mode(residual_mode), .hold(hold), .in_valid(in_valid),
        .in_ready(in_ready), .in_input(in_input), .in_weight(in_weight),
        .pe_en(pe_en), .pe_input_data(pe_input_data), .pe_weight_data(pe_weight_data),
        .pe_mode_residual(pe_mode_residual), .busy(busy), .done(done),
        .issued_count(issued_count), .skipped_count(skipped_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int done_cnt = 0, pe_cnt = 0, flush_cnt = 0, res_bad = 0, src_idx = 0;
    bit chk_res = 1'b0;
    logic [15:0] src_in[$], src_w[$];
    logic [31:0] obs_q[$], exp_q[$];
    logic [15:0] pe_acc, pe_out, done_pe_out;

    // Behavioural PE: accumulates on en, output register refreshed only on en.
    always @(posedge clk) begin
        if (rst) begin
            pe_acc <= '0;
            pe_out <= '0;
        end else if (pe_en) begin
            pe_acc <= pe_acc + 16'(pe_input_data * pe_weight_data);
            pe_out <= pe_acc;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                done_cnt++;
                done_pe_out = pe_out;
            end
            if (pe_en) begin
                pe_cnt++;
                if (pe_input_data == '0 && pe_weight_data == '0) flush_cnt++;
                else obs_q.push_back({pe_input_data, pe_weight_data});
            end
            if (busy && chk_res && !pe_mode_residual) res_bad++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_sp(input logic [15:0] x);
        int v, m;
        v = int'($signed(x));
        m = (v < 0) ? -v : v;
        return (m < 16) || (v == 0);
    endfunction

    task automatic build_exp();
        exp_q.delete();
        foreach (src_in[i])
            if (!(is_sp(src_in[i]) || is_sp(src_w[i]))) exp_q.push_back({src_in[i], src_w[i]});
    endtask

    task automatic cmp_order(input string tag);
        int m = 0;
        chk({tag, "_n"}, obs_q.size(), exp_q.size());
        foreach (exp_q[i]) if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) m++;
        chk(tag, m, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        hold = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic start_op(input logic [15:0] n, input logic res);
        @(negedge clk);
        start = 1'b1;
        vec_len = n;
        residual_mode = res;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic drive_cycle(input bit v, input bit h);
        bit hs;
        @(negedge clk);
        in_valid  = v && (src_idx < src_in.size());
        in_input  = (src_idx < src_in.size()) ? src_in[src_idx] : 16'h0;
        in_weight = (src_idx < src_in.size()) ? src_w[src_idx] : 16'h0;
        hold = h;
        hs = in_valid && in_ready;
        @(posedge clk);
        if (hs) src_idx++;
    endtask

    task automatic run_to_done(input bit rnd, input int budget);
        int d0 = done_cnt;
        int c = 0;
        while (done_cnt == d0 && c < budget) begin
            if (rnd) drive_cycle(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) == 0));
            else     drive_cycle(1'b1, 1'b0);
            c++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        hold = 1'b0;
        chk("done_seen", done_cnt - d0, 1);
    endtask

    task automatic load(input logic [15:0] a, input logic [15:0] b);
        src_in.push_back(a);
        src_w.push_back(b);
    endtask

    task automatic new_src();
        src_in.delete();
        src_w.delete();
        obs_q.delete();
        src_idx = 0;
    endtask

    initial begin
        int p0, f0, d0, c;
        do_reset();
        @(negedge clk);
        chk("rst_pe_en", pe_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_issued", issued_count, 0);
        chk("rst_skipped", skipped_count, 0);
        chk("rst_resid", pe_mode_residual, 0);
        chk("rst_data", {pe_input_data, pe_weight_data}, 0);
        chk("rst_in_ready", in_ready, 0);

        // Threshold boundary.
        new_src();
        load(16'h0010, 16'h0010); load(16'h000F, 16'h0100); load(16'hFFF0, 16'h0020);
        load(16'hFFF1, 16'h0020); load(16'h8000, 16'h0001);
        f0 = flush_cnt;
        start_op(16'd5, 1'b0);
        run_to_done(1'b0, 200);
        chk("thr_issued", issued_count, 2);
        chk("thr_skipped", skipped_count, 3);
        chk("thr_n", obs_q.size(), 2);
        if (obs_q.size() == 2) begin
            chk("thr_pair0", obs_q[0], 32'h0010_0010);
            chk("thr_pair1", obs_q[1], 32'hFFF0_0020);
        end
        chk("thr_flush", flush_cnt - f0, 2);

        // Dot product into the PE model.
        do_reset();
        new_src();
        load(16'h0020, 16'h0030); load(16'h0005, 16'h0100);
        load(16'h0040, 16'h0000); load(16'hFFE0, 16'h0010);
        f0 = flush_cnt;
        start_op(16'd4, 1'b0);
        run_to_done(1'b0, 200);
        chk("dot_out", done_pe_out, 16'h0400);
        chk("dot_issued", issued_count, 2);
        chk("dot_skipped", skipped_count, 2);
        chk("dot_flush", flush_cnt - f0, 2);

        // Backpressure: hold while the FIFO fills.
        new_src();
        for (int i = 0; i < 12; i++) load(16'h0100 + 16'(i), 16'h0020 + 16'(i));
        build_exp();
        p0 = pe_cnt;
        f0 = flush_cnt;
        start_op(16'd12, 1'b0);
        repeat (15) drive_cycle(1'b1, 1'b1);
        #1;
        chk("bp_pushes", src_idx, 8);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_pe_quiet", pe_cnt - p0, 0);
        run_to_done(1'b0, 300);
        chk("bp_issued", issued_count, 12);
        cmp_order("bp_order");
        chk("bp_flush", flush_cnt - f0, 2);

        // Zero length.
        p0 = pe_cnt;
        d0 = done_cnt;
        start_op(16'd0, 1'b0);
        @(negedge clk);
        chk("zl_busy", busy, 1);
        chk("zl_done_early", done, 0);
        @(negedge clk);
        chk("zl_done", done, 1);
        chk("zl_busy_after", busy, 0);
        @(negedge clk);
        chk("zl_done_pulse", done, 0);
        chk("zl_no_pe", pe_cnt - p0, 0);
        chk("zl_count", done_cnt - d0, 1);

        // Start while busy is ignored.
        new_src();
        for (int i = 0; i < 7; i++) load(16'h0200 + 16'(i), 16'h0030);
        start_op(16'd3, 1'b0);
        drive_cycle(1'b1, 1'b0);
        #1;
        start = 1'b1;
        vec_len = 16'd7;
        drive_cycle(1'b1, 1'b0);
        #1 start = 1'b0;
        run_to_done(1'b0, 200);
        chk("sb_accepted", src_idx, 3);
        chk("sb_issued", issued_count, 3);

        // Reset mid-run.
        new_src();
        for (int i = 0; i < 6; i++) load(16'h0300 + 16'(i), 16'h0040);
        start_op(16'd6, 1'b1);
        c = 0;
        while (src_idx < 3 && c < 50) begin
            drive_cycle(1'b1, 1'b0);
            c++;
        end
        chk("mr_reached", src_idx, 3);
        #1;
        in_valid = 1'b0;
        rst = 1'b1;
        d0 = done_cnt;
        @(posedge clk);
        @(negedge clk);
        chk("mr_outputs", {pe_en, busy, done, in_ready, pe_mode_residual}, 0);
        chk("mr_counts", {issued_count, skipped_count}, 0);
        chk("mr_data", {pe_input_data, pe_weight_data}, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("mr_no_done", done_cnt - d0, 0);
        new_src();
        load(16'h0050, 16'h0060); load(16'h0003, 16'h0060);
        start_op(16'd2, 1'b0);
        run_to_done(1'b0, 100);
        chk("mr_issued", issued_count, 1);
        chk("mr_skipped", skipped_count, 1);

        // Residual mode with random valid/hold.
        new_src();
        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 5))
                0:       load(16'($urandom_range(0, 20)), 16'($urandom));
                1:       load(16'($urandom), 16'hFFF0 + 16'($urandom_range(0, 15)));
                2:       load(16'h8000, 16'($urandom));
                default: load(16'($urandom), 16'($urandom));
            endcase
        end
        build_exp();
        chk_res = 1'b1;
        start_op(16'd1000, 1'b1);
        run_to_done(1'b1, 20000);
        chk_res = 1'b0;
        chk("rnd_resid_run", res_bad, 0);
        chk("rnd_resid_held", pe_mode_residual, 1);
        chk("rnd_sum", 32'(issued_count) + 32'(skipped_count), 1000);
        chk("rnd_issued", issued_count, exp_q.size());
        cmp_order("rnd_order");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end
endmodule
